// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM states and the operand-forwarding priority function.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    typedef enum logic {
        HZ_RUN      = 1'b0,
        HZ_MDU_WAIT = 1'b1
    } hz_state_t;

    // The youngest producer wins. A load in EX has no data yet, so it never forwards.
    function automatic logic [1:0] fwd_pick(
        input logic [4:0] rs,
        input logic [4:0] ex_rd,
        input logic       ex_we,
        input logic       ex_ld,
        input logic [4:0] mem_rd,
        input logic       mem_we
    );
        if (ex_we && !ex_ld && (ex_rd != 5'd0) && (rs == ex_rd))
            return FWD_EXMEM;
        else if (mem_we && (mem_rd != 5'd0) && (rs == mem_rd))
            return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational rd/rs comparison producing the next operand forwarding selects
// for the instruction currently in ID.
module hazard_ctrl_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_we,
    input  logic       ex_is_load,
    input  logic [4:0] mem_rd,
    input  logic       mem_we,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b
);

    assign fwd_a = fwd_pick(rs1, ex_rd, ex_we, ex_is_load, mem_rd, mem_we);
    assign fwd_b = fwd_pick(rs2, ex_rd, ex_we, ex_is_load, mem_rd, mem_we);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, EX redirects,
// multi-cycle MDU sequencing, registered forwarding selects and perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs1_re_i,
    input  logic             id_rs2_re_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_we_i,
    input  logic             ex_is_load_i,
    input  logic             ex_mdu_i,
    input  logic             ex_back_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_we_i,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_stall_o,
    output logic             idex_flush_o,
    output logic             exmem_bubble_o,
    output logic             mdu_last_o,
    output logic [1:0]       fwd_a_sel_o,
    output logic [1:0]       fwd_b_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             dbg_state_o
);

    localparam int            CW       = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);

    hz_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
    logic          exmem_bubble, mdu_last, redirect, load_use;
    logic [1:0]    fwd_a_nxt, fwd_b_nxt;

    hazard_ctrl_fwd_unit u_fwd (
        .rs1        (id_rs1_i),
        .rs2        (id_rs2_i),
        .ex_rd      (ex_rd_i),
        .ex_we      (ex_we_i),
        .ex_is_load (ex_is_load_i),
        .mem_rd     (mem_rd_i),
        .mem_we     (mem_we_i),
        .fwd_a      (fwd_a_nxt),
        .fwd_b      (fwd_b_nxt)
    );

    assign load_use = ex_is_load_i && ex_we_i && (ex_rd_i != 5'd0) &&
                      ((id_rs1_re_i && (id_rs1_i == ex_rd_i)) ||
                       (id_rs2_re_i && (id_rs2_i == ex_rd_i)));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_flush   = 1'b0;
        exmem_bubble = 1'b0;
        mdu_last     = 1'b0;
        redirect     = 1'b0;
        case (state)
            HZ_RUN: begin
                if (ex_back_i) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    redirect   = 1'b1;
                end else if (ex_mdu_i) begin
                    if (MDU_LAT > 1) begin
                        pc_stall     = 1'b1;
                        ifid_stall   = 1'b1;
                        idex_stall   = 1'b1;
                        exmem_bubble = 1'b1;
                        cnt_nxt      = CNT_LOAD;
                        state_nxt    = HZ_MDU_WAIT;
                    end else begin
                        mdu_last = 1'b1;
                    end
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    ifid_stall = 1'b1;
                    idex_flush = 1'b1;
                end
            end
            HZ_MDU_WAIT: begin
                // Redirects cannot originate here: EX is occupied by the MDU op.
                if (cnt != '0) begin
                    pc_stall     = 1'b1;
                    ifid_stall   = 1'b1;
                    idex_stall   = 1'b1;
                    exmem_bubble = 1'b1;
                    cnt_nxt      = cnt - CW'(1);
                end else begin
                    mdu_last  = 1'b1;
                    state_nxt = HZ_RUN;
                end
            end
            default: state_nxt = HZ_RUN;
        endcase
    end

    // Reset must silence the pipeline controls even while EX inputs are live.
    assign pc_stall_o     = rst_n_i & pc_stall;
    assign ifid_stall_o   = rst_n_i & ifid_stall;
    assign ifid_flush_o   = rst_n_i & ifid_flush;
    assign idex_stall_o   = rst_n_i & idex_stall;
    assign idex_flush_o   = rst_n_i & idex_flush;
    assign exmem_bubble_o = rst_n_i & exmem_bubble;
    assign mdu_last_o     = rst_n_i & mdu_last;
    assign dbg_state_o    = state;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fwd_a_sel_o <= FWD_RF;
            fwd_b_sel_o <= FWD_RF;
        end else if (idex_flush) begin
            fwd_a_sel_o <= FWD_RF;
            fwd_b_sel_o <= FWD_RF;
        end else if (!idex_stall) begin
            fwd_a_sel_o <= fwd_a_nxt;
            fwd_b_sel_o <= fwd_b_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (pc_stall && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (redirect && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_LAT=4, CNT_W=4): each cycle's expected
// outputs go into a queue, and a negedge monitor pops and compares them.
module tb_hazard_ctrl;

    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1100100; // pc,ifid stall + idex flush
    localparam logic [6:0] C_MDU  = 7'b1101010; // pc,ifid,idex stall + bubble
    localparam logic [6:0] C_LAST = 7'b0000001;
    localparam logic [6:0] C_BACK = 7'b0010100; // ifid,idex flush

    logic       clk = 1'b0;
    logic       rst_n_i = 1'b0;
    logic [4:0] id_rs1_i = '0, id_rs2_i = '0, ex_rd_i = '0, mem_rd_i = '0;
    logic       id_rs1_re_i = 0, id_rs2_re_i = 0, ex_we_i = 0, ex_is_load_i = 0;
    logic       ex_mdu_i = 0, ex_back_i = 0, mem_we_i = 0;
    logic       pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o;
    logic       exmem_bubble_o, mdu_last_o, dbg_state_o;
    logic [1:0] fwd_a_sel_o, fwd_b_sel_o;
    logic [3:0] stall_cnt_o, flush_cnt_o;

    logic [19:0] exp_q[$];
    int checks = 0;
    int failures = 0;
    int vec_idx = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rs1_re_i    (id_rs1_re_i),
        .id_rs2_re_i    (id_rs2_re_i),
        .ex_rd_i        (ex_rd_i),
        .ex_we_i        (ex_we_i),
        .ex_is_load_i   (ex_is_load_i),
        .ex_mdu_i       (ex_mdu_i),
        .ex_back_i      (ex_back_i),
        .mem_rd_i       (mem_rd_i),
        .mem_we_i       (mem_we_i),
        .pc_stall_o     (pc_stall_o),
        .ifid_stall_o   (ifid_stall_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_stall_o   (idex_stall_o),
        .idex_flush_o   (idex_flush_o),
        .exmem_bubble_o (exmem_bubble_o),
        .mdu_last_o     (mdu_last_o),
        .fwd_a_sel_o    (fwd_a_sel_o),
        .fwd_b_sel_o    (fwd_b_sel_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .dbg_state_o    (dbg_state_o)
    );

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Monitor: every cycle is an output beat, sampled on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [19:0] e;
            logic [19:0] a;
            e = exp_q.pop_front();
            a = {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_stall_o, idex_flush_o,
                 exmem_bubble_o, mdu_last_o, fwd_a_sel_o, fwd_b_sel_o,
                 stall_cnt_o, flush_cnt_o, dbg_state_o};
            chk("ctl",       vec_idx, {1'b0, a[19:13]}, {1'b0, e[19:13]});
            chk("fwd",       vec_idx, {4'b0, a[12:9]},  {4'b0, e[12:9]});
            chk("stall_cnt", vec_idx, {4'b0, a[8:5]},   {4'b0, e[8:5]});
            chk("flush_cnt", vec_idx, {4'b0, a[4:1]},   {4'b0, e[4:1]});
            chk("state",     vec_idx, {7'b0, a[0]},     {7'b0, e[0]});
            vec_idx++;
        end
    end

    // Driver: apply one cycle of inputs just after the rising edge and queue its expectation.
    task automatic cyc(
        input logic rst, input logic [4:0] rs1, rs2, input logic re1, re2,
        input logic [4:0] exrd, input logic exwe, exld, exmdu, exback,
        input logic [4:0] memrd, input logic memwe,
        input logic [6:0] ctl, input logic [1:0] fa, fb,
        input logic [3:0] sc, fc, input logic st
    );
        @(posedge clk);
        #1;
        rst_n_i      = rst;
        id_rs1_i     = rs1;
        id_rs2_i     = rs2;
        id_rs1_re_i  = re1;
        id_rs2_re_i  = re2;
        ex_rd_i      = exrd;
        ex_we_i      = exwe;
        ex_is_load_i = exld;
        ex_mdu_i     = exmdu;
        ex_back_i    = exback;
        mem_rd_i     = memrd;
        mem_we_i     = memwe;
        exp_q.push_back({ctl, fa, fb, sc, fc, st});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        cyc(0, 0,0,0,0, 0,0,0,0,0, 0,0, C_NONE, 0,0, 0,0, 0);
        cyc(0, 0,0,0,0, 0,0,0,0,0, 0,0, C_NONE, 0,0, 0,0, 0);
        cyc(1, 0,0,0,0, 0,0,0,0,0, 0,0, C_NONE, 0,0, 0,0, 0);
        // load-use on x5, then the load forwards from MEM/WB
        cyc(1, 5,0,1,0, 5,1,1,0,0, 0,0, C_LU,   0,0, 0,0, 0);
        cyc(1, 5,0,1,0, 0,0,0,0,0, 5,1, C_NONE, 0,0, 1,0, 0);
        cyc(1, 0,0,0,0, 0,0,0,0,0, 0,0, C_NONE, 2,0, 1,0, 0);
        // EX beats MEM on rs2; rd=0 never forwards; MEM-only on both operands
        cyc(1, 0,3,0,1, 3,1,0,0,0, 3,1, C_NONE, 0,0, 1,0, 0);
        cyc(1, 0,0,0,1, 0,1,0,0,0, 0,1, C_NONE, 0,1, 1,0, 0);
        cyc(1, 7,7,1,1, 0,0,0,0,0, 7,1, C_NONE, 0,0, 1,0, 0);
        cyc(1, 0,0,0,0, 0,0,0,0,0, 0,0, C_NONE, 2,2, 1,0, 0);
        // MDU: 3 stalls, selects held, redirect ignored while waiting, last in 4th cycle
        cyc(1, 7,0,1,0, 0,0,0,1,0, 7,1, C_MDU,  0,0, 1,0, 0);
        cyc(1, 7,0,1,0, 0,0,0,1,1, 7,1, C_MDU,  0,0, 2,0, 1);
        cyc(1, 7,0,1,0, 0,0,0,1,0, 7,1, C_MDU,  0,0, 3,0, 1);
        cyc(1, 7,0,1,0, 0,0,0,1,0, 7,1, C_LAST, 0,0, 4,0, 1);
        cyc(1, 9,0,1,0, 9,1,0,0,0, 0,0, C_NONE, 2,0, 4,0, 0);
        // redirect clears the EX/MEM forward that would otherwise load
        cyc(1, 9,0,1,0, 9,1,0,0,1, 0,0, C_BACK, 1,0, 4,0, 0);
        cyc(1, 0,0,0,0, 0,0,0,0,0, 0,0, C_NONE, 0,0, 4,1, 0);
        // reset mid-MDU (cnt=2), then a full restart
        cyc(1, 0,0,0,0, 0,0,0,1,0, 0,0, C_MDU,  0,0, 4,1, 0);
        cyc(0, 0,0,0,0, 0,0,0,1,0, 0,0, C_NONE, 0,0, 0,0, 0);
        cyc(1, 0,0,0,0, 0,0,0,1,0, 0,0, C_MDU,  0,0, 0,0, 0);
        cyc(1, 0,0,0,0, 0,0,0,1,0, 0,0, C_MDU,  0,0, 1,0, 1);
        cyc(1, 0,0,0,0, 0,0,0,1,0, 0,0, C_MDU,  0,0, 2,0, 1);
        cyc(1, 0,0,0,0, 0,0,0,1,0, 0,0, C_LAST, 0,0, 3,0, 1);
        cyc(1, 0,0,0,0, 0,0,0,0,0, 0,0, C_NONE, 0,0, 3,0, 0);
        // 20 load-use stalls: the 4-bit stall counter must stick at 15
        for (int i = 0; i < 20; i++) begin
            logic [3:0] sc;
            sc = (3 + i > 15) ? 4'hF : 4'(3 + i);
            cyc(1, 5,0,1,0, 5,1,1,0,0, 0,0, C_LU, 0,0, sc,0, 0);
        end
        cyc(1, 0,0,0,0, 0,0,0,0,0, 0,0, C_NONE, 0,0, 4'hF,0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
